// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the PC and pipelines requests on an SRAM-like bus.
// Returned instructions are PC-tagged and buffered in a queue that feeds decode.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'hBFC0_0000,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        branch_en_i,
  input  logic [31:0] branch_pc_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_inst_o,
  output logic        out_adel_o
);

  localparam int unsigned QW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;

  logic [31:0]   pc;
  logic          halted;
  logic [CW-1:0] count;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard;
  logic [QW-1:0] head;
  logic [QW-1:0] tail;
  logic [TW-1:0] tag_rd;
  logic [TW-1:0] tag_wr;

  logic [31:0] q_pc   [DEPTH];
  logic [31:0] q_inst [DEPTH];
  logic        q_adel [DEPTH];
  logic [31:0] tag_pc [MAX_OUTSTANDING];

  logic          redirect;
  logic [31:0]   target;
  logic [SW-1:0] reserved;
  logic          handshake;
  logic          resp;
  logic          resp_keep;
  logic          adel_push;
  logic          push;
  logic          pop;
  logic [31:0]   push_pc;
  logic [31:0]   push_inst;
  logic [OW-1:0] outstanding_nxt;

  function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
  endfunction

  // Issue/accept decisions; every live request holds a queue slot so the queue never overflows.
  always_comb begin
    redirect        = flush_i | branch_en_i;
    target          = flush_i ? flush_pc_i : branch_pc_i;
    reserved        = SW'(count) + SW'(outstanding) - SW'(discard);
    inst_req_o      = rst_n & !redirect & !halted & (pc[1:0] == 2'b00)
                    & (outstanding < OW'(MAX_OUTSTANDING)) & (reserved < SW'(DEPTH));
    handshake       = inst_req_o & inst_addr_ok_i;
    resp            = inst_data_ok_i & (outstanding != '0);
    resp_keep       = resp & (discard == '0) & !redirect;
    adel_push       = !redirect & !halted & (pc[1:0] != 2'b00)
                    & (outstanding == discard) & (count < CW'(DEPTH));
    push            = resp_keep | adel_push;
    pop             = out_valid_o & out_ready_i;
    push_pc         = adel_push ? pc : tag_pc[tag_rd];
    push_inst       = adel_push ? '0 : inst_rdata_i;
    outstanding_nxt = outstanding + OW'(handshake) - OW'(resp);
  end

  assign inst_addr_o = pc;
  assign out_valid_o = (count != '0);
  assign out_pc_o    = out_valid_o ? q_pc[head]   : '0;
  assign out_inst_o  = out_valid_o ? q_inst[head] : '0;
  assign out_adel_o  = out_valid_o & q_adel[head];

  // Control state: PC, pointers, counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      halted      <= 1'b0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      head        <= '0;
      tail        <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (handshake) tag_wr <= tag_next(tag_wr);
      if (resp)      tag_rd <= tag_next(tag_rd);
      if (redirect) begin
        pc      <= target;
        halted  <= 1'b0;
        count   <= '0;
        head    <= '0;
        tail    <= '0;
        discard <= outstanding - OW'(resp);
      end else begin
        if (handshake) pc <= pc + 32'd4;
        if (adel_push) halted <= 1'b1;
        if (resp && (discard != '0)) discard <= discard - OW'(1);
        if (push) tail <= tail + QW'(1);
        if (pop)  head <= head + QW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
    end
  end

  // Payload storage; contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (handshake) tag_pc[tag_wr] <= pc;
    if (push) begin
      q_pc[tail]   <= push_pc;
      q_inst[tail] <= push_inst;
      q_adel[tail] <= adel_push;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a single-cycle bus responder returning ~addr.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        branch_en = 1'b0;
  logic [31:0] branch_pc = '0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b1;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_adel;

  int          n_checks = 0;
  int          n_fail = 0;
  bit          resp_en = 1'b1;
  logic [31:0] pend[$];
  logic [31:0] exp_pc;
  bit          saw;

  always #5 clk = ~clk;

  if_fetch_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush),
    .flush_pc_i     (flush_pc),
    .branch_en_i    (branch_en),
    .branch_pc_i    (branch_pc),
    .inst_req_o     (inst_req),
    .inst_addr_o    (inst_addr),
    .inst_addr_ok_i (inst_addr_ok),
    .inst_data_ok_i (inst_data_ok),
    .inst_rdata_i   (inst_rdata),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_pc_o       (out_pc),
    .out_inst_o     (out_inst),
    .out_adel_o     (out_adel)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample the bus before the edge, then present the next response.
  task automatic tick();
    logic        hs;
    logic        rsp;
    logic [31:0] a;
    @(negedge clk);
    hs  = inst_req & inst_addr_ok;
    a   = inst_addr;
    rsp = inst_data_ok;
    @(posedge clk);
    #1;
    if (rsp && pend.size() > 0) void'(pend.pop_front());
    if (hs) pend.push_back(a);
    if (resp_en && pend.size() > 0) begin
      inst_data_ok = 1'b1;
      inst_rdata   = ~pend[0];
    end else begin
      inst_data_ok = 1'b0;
      inst_rdata   = '0;
    end
  endtask

  // Asynchronous mid-cycle reset; a stale response is left on the bus across release.
  task automatic do_reset();
    #2;
    rst_n        = 1'b0;
    flush        = 1'b0;
    branch_en    = 1'b0;
    out_ready    = 1'b1;
    resp_en      = 1'b1;
    pend.delete();
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hDEAD_BEEF;
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_req",   32'(inst_req),  32'd0);
    check_eq("rst_addr",  inst_addr,      32'hBFC0_0000);
    check_eq("rst_pc",    out_pc,         32'd0);
    check_eq("rst_inst",  out_inst,       32'd0);
    check_eq("rst_adel",  32'(out_adel),  32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 8 && !out_valid; k++) tick();
    check_eq(tag, 32'(out_valid), 32'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Streaming: one instruction per cycle from the reset PC.
    do_reset();
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'hBFC0_0000 + 32'(i) * 32'd4;
      check_eq("t1_valid", 32'(out_valid), 32'd1);
      check_eq("t1_pc",    out_pc,         exp_pc);
      check_eq("t1_inst",  out_inst,       ~exp_pc);
      tick();
    end

    // Decode stall fills the queue, then drains in order and fetch resumes.
    do_reset();
    out_ready = 1'b0;
    repeat (10) tick();
    check_eq("t2_req_low", 32'(inst_req), 32'd0);
    check_eq("t2_addr",    inst_addr,     32'hBFC0_0010);
    check_eq("t2_head",    out_pc,        32'hBFC0_0000);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_pc = 32'hBFC0_0000 + 32'(i) * 32'd4;
      check_eq("t2_drain_pc",   out_pc,   exp_pc);
      check_eq("t2_drain_inst", out_inst, ~exp_pc);
      tick();
    end

    // Branch with two requests in flight; late responses must be dropped.
    do_reset();
    resp_en = 1'b0;
    tick();
    tick();
    check_eq("t3_req_full", 32'(inst_req), 32'd0);
    branch_en = 1'b1;
    branch_pc = 32'h8000_1000;
    resp_en   = 1'b1;
    tick();
    branch_en = 1'b0;
    #1;
    check_eq("t3_valid_clr", 32'(out_valid), 32'd0);
    check_eq("t3_addr",      inst_addr,      32'h8000_1000);
    check_eq("t3_req_wait",  32'(inst_req),  32'd0);
    wait_valid("t3_valid");
    check_eq("t3_pc",   out_pc,   32'h8000_1000);
    check_eq("t3_inst", out_inst, ~32'h8000_1000);

    // Flush and branch together: flush target wins.
    repeat (3) tick();
    flush     = 1'b1;
    flush_pc  = 32'hBFC0_0380;
    branch_en = 1'b1;
    branch_pc = 32'h8000_2000;
    #1;
    check_eq("t4_req_forced", 32'(inst_req), 32'd0);
    tick();
    flush     = 1'b0;
    branch_en = 1'b0;
    #1;
    check_eq("t4_valid_clr", 32'(out_valid), 32'd0);
    check_eq("t4_addr",      inst_addr,      32'hBFC0_0380);
    wait_valid("t4_valid");
    check_eq("t4_pc",   out_pc,   32'hBFC0_0380);
    check_eq("t4_inst", out_inst, ~32'hBFC0_0380);

    // Misaligned target yields one address-error entry and halts fetch.
    repeat (2) tick();
    branch_en = 1'b1;
    branch_pc = 32'h8000_0002;
    tick();
    branch_en = 1'b0;
    wait_valid("t5_valid");
    check_eq("t5_pc",   out_pc,        32'h8000_0002);
    check_eq("t5_inst", out_inst,      32'd0);
    check_eq("t5_adel", 32'(out_adel), 32'd1);
    saw = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (inst_req || out_valid) saw = 1'b1;
    end
    check_eq("t5_halted", 32'(saw), 32'd0);
    branch_en = 1'b1;
    branch_pc = 32'h8000_0000;
    tick();
    branch_en = 1'b0;
    #1;
    check_eq("t5_resume_req",  32'(inst_req), 32'd1);
    check_eq("t5_resume_addr", inst_addr,     32'h8000_0000);

    // Reset in the middle of a stalled, partly full pipeline.
    do_reset();
    out_ready = 1'b0;
    repeat (4) tick();
    check_eq("t6_pre_valid", 32'(out_valid), 32'd1);
    do_reset();
    tick();
    tick();
    check_eq("t6_valid", 32'(out_valid), 32'd1);
    check_eq("t6_pc",    out_pc,         32'hBFC0_0000);
    check_eq("t6_inst",  out_inst,       ~32'hBFC0_0000);
    tick();
    check_eq("t6_next_pc", out_pc, 32'hBFC0_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
